// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state enumeration and a helper that turns an access size into
// a byte-lane mask over the low end of a 64-bit word.

package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } lsu_state_t;

    // Ones over the low 1/2/4/8 bytes selected by the access size.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 64'h0000_0000_0000_00FF;
            SZ_HALF: return 64'h0000_0000_0000_FFFF;
            SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align
// Purely combinational data alignment for the load/store unit.
//   size         : access width (SZ_BYTE..SZ_DWORD)
//   is_signed    : sign-extend the load result
//   mem_word     : 64-bit word read from memory at the access address
//   store_data   : low-aligned store data
//   load_value   : low bytes of mem_word, zero- or sign-extended to 64 bits
//   merged_value : mem_word with its low bytes replaced by store_data

module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [63:0] mem_word,
    input  logic [63:0] store_data,
    output logic [63:0] load_value,
    output logic [63:0] merged_value
);

    logic [63:0] mask;
    logic        sign_bit;

    always_comb begin
        mask = size_mask(size);
        case (size)
            SZ_BYTE: sign_bit = mem_word[7];
            SZ_HALF: sign_bit = mem_word[15];
            SZ_WORD: sign_bit = mem_word[31];
            default: sign_bit = mem_word[63];
        endcase
        // For a doubleword ~mask is zero, so extension is a no-op there.
        load_value   = (mem_word & mask) | ((is_signed && sign_bit) ? ~mask : 64'd0);
        merged_value = (mem_word & ~mask) | (store_data & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Single-outstanding load/store controller between the pipeline and a
// 64-bit little-endian byte-addressed data memory (combinational read,
// write on the rising edge). Sub-word stores use read-modify-write.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake
//   req_write, req_size, req_signed: store/load, width, load sign extension
//   req_addr, req_wdata            : byte address, low-aligned store data
//   resp_valid/resp_ready          : response handshake
//   resp_rdata, resp_err           : load data (0 for stores), error flag
//   mem_address, mem_data_in       : memory address and write data
//   mem_read, mem_write            : memory strobes
//   mem_data_out                   : memory read data
//
// Configuration:
//   LSU_BOUNDS_CHECK_EN : when defined, requests whose 8-byte window would
//   reach past MEM_BYTES are answered with resp_err=1 without touching
//   memory. When undefined, resp_err is constant 0 and addresses are not
//   checked.

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_address,
    output logic [63:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_data_out
);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [63:0] data_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        out_of_bounds;
    logic [63:0] load_value;
    logic [63:0] merged_value;

    assign accept = (state == IDLE) && req_valid;

`ifdef LSU_BOUNDS_CHECK_EN
    logic err_q;

    // Widened by one bit so a huge address cannot wrap past the limit.
    assign out_of_bounds = ({1'b0, req_addr} + 65'd7) >= 65'(MEM_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= out_of_bounds;
        end
    end

    assign resp_err = err_q;
`else
    assign out_of_bounds = 1'b0;
    assign resp_err      = 1'b0;
`endif

    lsu_align u_align (
        .size         (size_q),
        .is_signed    (signed_q),
        .mem_word     (mem_data_out),
        .store_data   (data_q),
        .load_value   (load_value),
        .merged_value (merged_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (out_of_bounds) begin
                        state_next = RESP;
                    end else if (!req_write) begin
                        state_next = LOAD;
                    end else if (req_size == SZ_DWORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_READ;
                    end
                end
            end
            LOAD:     state_next = RESP;
            RMW_READ: state_next = WRITE;
            WRITE:    state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // data_q first holds the raw store data, then the merged word after
    // RMW_READ, so WRITE always drives mem_data_in from the same register.
    // rdata_q is cleared on acceptance so stores and errors answer with 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= 64'd0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            data_q   <= 64'd0;
            rdata_q  <= 64'd0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                data_q   <= req_wdata;
                rdata_q  <= 64'd0;
            end
            if (state == LOAD) begin
                rdata_q <= load_value;
            end
            if (state == RMW_READ) begin
                data_q <= merged_value;
            end
        end
    end

    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 64'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            LOAD, RMW_READ: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
            end
            WRITE: begin
                mem_write   = 1'b1;
                mem_address = addr_q;
            end
            RESP: begin
                resp_valid  = 1'b1;
                mem_address = addr_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign mem_data_in = data_q;
    assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed scenarios followed by
// random loads/stores compared against a byte-array reference model.
// Build with +define+LSU_BOUNDS_CHECK_EN to include the bounds scenarios.

module tb_load_store_unit;

    localparam int MEM_BYTES = 128;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_address;
    logic [63:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_data_out;

    logic        init_mem;
    logic [7:0]  mem       [MEM_BYTES];
    logic [7:0]  model_mem [MEM_BYTES];

    int          checks;
    int          errors;
    int          rd_cnt;
    int          wr_cnt;
    int          illegal_cnt;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read of 8 bytes, write on the rising edge.
    always_comb begin
        mem_data_out = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (mem_address + 64'(i) < 64'(MEM_BYTES)) begin
                mem_data_out[8*i +: 8] = mem[int'(mem_address) + i];
            end
        end
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i);
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_address + 64'(i) < 64'(MEM_BYTES)) begin
                    mem[int'(mem_address) + i] <= mem_data_in[8*i +: 8];
                end
            end
        end
    end

    // Strobe counters and protocol watch: no simultaneous read/write, and no
    // memory activity while idle or while a response is pending.
    initial begin
        rd_cnt = 0;
        wr_cnt = 0;
        illegal_cnt = 0;
    end

    always @(negedge clk) begin
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read && mem_write) illegal_cnt++;
        if ((req_ready || resp_valid) && (mem_read || mem_write)) illegal_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sizeBytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [63:0] modelLoad(input int a, input logic [1:0] sz, input logic sg);
        logic [63:0] v;
        int n;
        n = sizeBytes(sz);
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(model_mem[a + i]) << (8 * i));
        if (sg && n < 8 && v[8*n - 1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic modelStore(input int a, input logic [1:0] sz, input logic [63:0] wd);
        for (int i = 0; i < sizeBytes(sz); i++) model_mem[a + i] = wd[8*i +: 8];
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    task automatic resetDut(input logic with_init);
        @(negedge clk);
        reset      = 1'b1;
        init_mem   = with_init;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        init_mem = 1'b0;
    endtask

    // One full transaction; hold > 0 keeps resp_ready low that many extra
    // cycles while checking the response stays frozen.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [63:0] addr, input logic [63:0] wd, input int hold,
                                 output logic [63:0] rd, output logic er, output int lat,
                                 output int nr, output int nw);
        int r0;
        int w0;
        @(negedge clk);
        checkOutput("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (lat >= 20) checkOutput("resp_timeout", 64'(resp_valid), 64'd1);
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(resp_valid), 64'd1);
            checkOutput("hold_rdata", resp_rdata, rd);
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        nr = rd_cnt - r0;
        nw = wr_cnt - w0;
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic        er;
        logic        wr;
        logic        sg;
        logic [1:0]  sz;
        int          lat;
        int          nr;
        int          nw;
        int          a;
        int          w0;
        int          diffs;

        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        init_mem   = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'(i);

        resetDut(1'b1);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
        checkOutput("rst_mem_read", 64'(mem_read), 64'd0);
        checkOutput("rst_mem_write", 64'(mem_write), 64'd0);

        // Doubleword load of the identity-initialised memory.
        applyStimulus(1'b0, 2'b11, 1'b0, 64'd0, 64'd0, 0, rd, er, lat, nr, nw);
        checkOutput("ld_d0_rdata", rd, 64'h0706_0504_0302_0100);
        checkOutput("ld_d0_lat", 64'(lat), 64'd2);
        checkOutput("ld_d0_reads", 64'(nr), 64'd1);
        checkOutput("ld_d0_writes", 64'(nw), 64'd0);

        // Byte store then signed and unsigned byte loads.
        applyStimulus(1'b1, 2'b00, 1'b0, 64'd16, 64'hDEAD_BEEF_1234_5680, 0, rd, er, lat, nr, nw);
        modelStore(16, 2'b00, 64'hDEAD_BEEF_1234_5680);
        checkOutput("st_b_rdata", rd, 64'd0);
        checkOutput("st_b_lat", 64'(lat), 64'd3);
        checkOutput("st_b_reads", 64'(nr), 64'd1);
        checkOutput("st_b_writes", 64'(nw), 64'd1);
        applyStimulus(1'b0, 2'b00, 1'b1, 64'd16, 64'd0, 0, rd, er, lat, nr, nw);
        checkOutput("ld_b_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
        applyStimulus(1'b0, 2'b00, 1'b0, 64'd16, 64'd0, 0, rd, er, lat, nr, nw);
        checkOutput("ld_b_unsigned", rd, 64'h0000_0000_0000_0080);
        checkOutput("mem17_kept", 64'(mem[17]), 64'h11);

        // Half store must leave the neighbouring bytes untouched.
        applyStimulus(1'b1, 2'b01, 1'b0, 64'd8, 64'h0000_0000_0000_BEEF, 0, rd, er, lat, nr, nw);
        modelStore(8, 2'b01, 64'hBEEF);
        checkOutput("st_h_reads", 64'(nr), 64'd1);
        checkOutput("st_h_writes", 64'(nw), 64'd1);
        checkOutput("st_h_byte8", 64'(mem[8]), 64'hEF);
        checkOutput("st_h_byte9", 64'(mem[9]), 64'hBE);
        for (int i = 10; i < 16; i++) checkOutput("st_h_upper", 64'(mem[i]), 64'(i));

        // Response held off for 3 cycles.
        applyStimulus(1'b0, 2'b10, 1'b1, 64'd6, 64'd0, 3, rd, er, lat, nr, nw);
        checkOutput("hold_ld_rdata", rd, modelLoad(6, 2'b10, 1'b1));
        checkOutput("hold_ld_lat", 64'(lat), 64'd2);
        checkOutput("hold_ld_reads", 64'(nr), 64'd1);

        // Doubleword store goes straight to WRITE.
        applyStimulus(1'b1, 2'b11, 1'b0, 64'd40, 64'h8877_6655_4433_2211, 0, rd, er, lat, nr, nw);
        modelStore(40, 2'b11, 64'h8877_6655_4433_2211);
        checkOutput("st_d_lat", 64'(lat), 64'd2);
        checkOutput("st_d_reads", 64'(nr), 64'd0);
        checkOutput("st_d_writes", 64'(nw), 64'd1);
        checkOutput("st_d_byte47", 64'(mem[47]), 64'h88);

`ifdef LSU_BOUNDS_CHECK_EN
        applyStimulus(1'b0, 2'b11, 1'b0, 64'd121, 64'd0, 0, rd, er, lat, nr, nw);
        checkOutput("oob_err", 64'(er), 64'd1);
        checkOutput("oob_rdata", rd, 64'd0);
        checkOutput("oob_reads", 64'(nr), 64'd0);
        checkOutput("oob_lat", 64'(lat), 64'd1);
        applyStimulus(1'b1, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd5, 0, rd, er, lat, nr, nw);
        checkOutput("oob_wrap_err", 64'(er), 64'd1);
        checkOutput("oob_wrap_writes", 64'(nw), 64'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 64'd120, 64'd0, 0, rd, er, lat, nr, nw);
        checkOutput("edge_err", 64'(er), 64'd0);
        checkOutput("edge_rdata", rd, modelLoad(120, 2'b11, 1'b0));
`endif

        // Reset during RMW_READ of a byte store: nothing may be written.
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 64'd4;
        req_wdata = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checkOutput("rmw_rst_read", 64'(mem_read), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rmw_rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rmw_rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rmw_rst_byte4", 64'(mem[4]), 64'h04);
        checkOutput("rmw_rst_no_write", 64'(wr_cnt - w0), 64'd0);

        // Reset coincident with WRITE: the write lands, no response follows.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b11;
        req_addr  = 64'd32;
        req_wdata = 64'hA1B2_C3D4_E5F6_0718;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelStore(32, 2'b11, 64'hA1B2_C3D4_E5F6_0718);
        repeat (2) begin
            @(negedge clk);
            checkOutput("wr_rst_resp_valid", 64'(resp_valid), 64'd0);
        end
        checkOutput("wr_rst_byte32", 64'(mem[32]), 64'h18);
        checkOutput("wr_rst_byte39", 64'(mem[39]), 64'hA1);

        // Random traffic against the byte-array model.
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom);
            sz = 2'($urandom);
            sg = 1'($urandom);
            a  = int'($urandom_range(0, MEM_BYTES - 8));
            wd = {$urandom, $urandom};
            exp_rd = wr ? 64'd0 : modelLoad(a, sz, sg);
            applyStimulus(wr, sz, sg, 64'(a), wd, 0, rd, er, lat, nr, nw);
            if (wr) modelStore(a, sz, wd);
            checkOutput("rnd_rdata", rd, exp_rd);
            checkOutput("rnd_err", 64'(er), 64'd0);
            checkOutput("rnd_lat", 64'(lat), (wr && sz != 2'b11) ? 64'd3 : 64'd2);
            checkOutput("rnd_reads", 64'(nr), (wr && sz == 2'b11) ? 64'd0 : 64'd1);
            checkOutput("rnd_writes", 64'(nw), wr ? 64'd1 : 64'd0);
        end

        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== model_mem[i]) diffs++;
        checkOutput("mem_image_diffs", 64'(diffs), 64'd0);
        checkOutput("protocol_violations", 64'(illegal_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 128, SHALL give the data memory size in bytes, used for bounds checking.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL indicate an access request from the pipeline.
REQ-005 req_ready  output  1  SHALL be high only in IDLE; a request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 req_write  input  1  SHALL select store (1) or load (0).
REQ-007 req_size  input  2  SHALL select the access width: 00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 req_signed  input  1  SHALL select sign extension for loads; ignored for stores.
REQ-009 req_addr  input  64  SHALL be the byte address; req_wdata  input  64  SHALL be the store data, low-aligned.
REQ-010 resp_valid  output  1, resp_ready  input  1, resp_rdata  output  64, resp_err  output  1  SHALL form the response channel.
REQ-011 mem_address  output  64, mem_data_in  output  64, mem_read  output  1, mem_write  output  1, mem_data_out  input  64  SHALL connect to the 64-bit little-endian byte-addressed data memory (combinational read, write on rising edge).

Function
REQ-012 FSM states SHALL be IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-013 On acceptance, addr/size/signed/wdata SHALL be registered; mem_address SHALL be driven from the registered address in all non-IDLE states.
REQ-014 IDLE->LOAD for loads; IDLE->WRITE for doubleword stores; IDLE->RMW_READ for byte/half/word stores.
REQ-015 LOAD SHALL assert mem_read for exactly one cycle, capture mem_data_out, extract the low 1/2/4/8 bytes, zero- or sign-extend to 64 bits, then go to RESP.
REQ-016 RMW_READ SHALL assert mem_read for one cycle, capture mem_data_out, and merge the low 1/2/4 bytes of wdata into it, preserving the upper bytes; then go to WRITE.
REQ-017 WRITE SHALL assert mem_write for exactly one cycle with mem_data_in = wdata (doubleword) or the merged word; then go to RESP.
REQ-018 mem_read and mem_write SHALL never be asserted in the same cycle and SHALL both be low in IDLE and RESP.
REQ-019 RESP SHALL hold resp_valid, resp_rdata, resp_err stable until resp_ready is high at an edge, then return to IDLE; resp_rdata SHALL be 0 for stores.
REQ-020 Latency: load response SHALL appear 2 cycles after acceptance; doubleword store 2 cycles; sub-word store 3 cycles (with resp_ready held high).
REQ-021 A new request SHALL NOT be accepted in the cycle the response handshake completes (req_ready rises the following cycle).

Reset
REQ-022 Reset SHALL force IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, captured registers=0.
REQ-023 Reset during LOAD/RMW_READ/RESP SHALL abandon the access with no memory write; reset coincident with WRITE SHALL still let that cycle's write land, and no response SHALL be produced.

Configuration
REQ-024 With LSU_BOUNDS_CHECK_EN defined, an accepted request with req_addr + 7 >= MEM_BYTES SHALL skip all memory states, go directly to RESP with resp_err=1 and resp_rdata=0, and never assert mem_read/mem_write.
REQ-025 Without LSU_BOUNDS_CHECK_EN, resp_err SHALL be tied 0 and all addresses SHALL be passed through unchecked.

Structure
REQ-026 A shared package SHALL hold the size encodings (SZ_BYTE..SZ_DWORD) and the FSM state enumeration.
REQ-027 Byte extraction/extension and merge logic SHALL be one combinational sub-module, lsu_align, instanced twice or shared.

Verification
REQ-028 Memory init byte i = i; load doubleword at addr 0 -> resp_rdata 0x0706050403020100, resp_valid 2 cycles after accept.
REQ-029 Store byte 0x80 at addr 16, then signed byte load at 16 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x0000000000000080.
REQ-030 Store half 0xBEEF at addr 8 -> bytes 8,9 = 0xEF,0xBE; bytes 10..15 remain 0x0A..0x0F; one mem_read then one mem_write pulse.
REQ-031 With LSU_BOUNDS_CHECK_EN, load at addr 121 -> resp_err=1, resp_rdata=0, mem_read never asserted; addr 120 -> resp_err=0.
REQ-032 resp_ready held low 3 cycles during RESP -> resp_valid/resp_rdata stable, req_ready low, no memory activity.
REQ-033 Reset asserted in RMW_READ of a byte store to addr 4 -> byte 4 stays 0x04, req_ready=1 the cycle after reset deasserts.
